regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 135 +++++++++++++
 tb/tb_regfile_writeback.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Write-back queue: arbitrates ALU and load-unit results into a DEPTH-entry FIFO
// drained one entry per cycle into the register file. Optional macro: WB_FORWARD_EN.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                   elk,
  input  logic                   nrst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_addr,
  input  logic [31:0]            alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [4:0]             mem_addr,
  input  logic [31:0]            mem_data,
  input  logic                   rf_stall,
  output logic                   wr_en,
  output logic [4:0]             wr_addr,
  output logic [31:0]            wr_data,
  output logic [$clog2(DEPTH):0] pending_cnt,
  input  logic [4:0]             fwd_addr,
  output logic                   fwd_hit,
  output logic [31:0]            fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rr_mem;
  logic [4:0]       r_q_addr [DEPTH];
  logic [31:0]      r_q_data [DEPTH];

  logic        w_full;
  logic        w_empty;
  logic        w_grant_alu;
  logic        w_grant_mem;
  logic        w_alu_xfer;
  logic        w_mem_xfer;
  logic        w_contended;
  logic        w_push;
  logic        w_pop;
  logic [4:0]  w_push_addr;
  logic [31:0] w_push_data;

  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Contended cycles follow the round-robin bit; a lone requester is always granted.
  assign w_contended = alu_valid && mem_valid;

  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_mem = 1'b0;
    if (w_contended) begin
      w_grant_mem = r_rr_mem;
      w_grant_alu = !r_rr_mem;
    end else begin
      w_grant_alu = alu_valid;
      w_grant_mem = mem_valid;
    end
  end

  assign alu_ready = nrst && !w_full && w_grant_alu;
  assign mem_ready = nrst && !w_full && w_grant_mem;

  assign w_alu_xfer  = alu_valid && alu_ready;
  assign w_mem_xfer  = mem_valid && mem_ready;
  assign w_push_addr = w_mem_xfer ? mem_addr : alu_addr;
  assign w_push_data = w_mem_xfer ? mem_data : alu_data;

  // Writes to r0 are acknowledged but never occupy a queue slot.
  assign w_push = (w_alu_xfer || w_mem_xfer) && (w_push_addr != 5'd0);
  assign w_pop  = !w_empty && !rf_stall;

  assign wr_en       = w_pop;
  assign wr_addr     = w_empty ? 5'd0  : r_q_addr[r_rptr];
  assign wr_data     = w_empty ? 32'd0 : r_q_data[r_rptr];
  assign pending_cnt = r_cnt;

  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_rr_mem <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_contended && (w_alu_xfer || w_mem_xfer)) begin
        r_rr_mem <= !r_rr_mem;
      end
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge elk) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= w_push_addr;
      r_q_data[r_wptr] <= w_push_data;
    end
  end

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the last match seen is the most recent result.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rptr + PTR_W'(i);
      if ((CNT_W'(i) < r_cnt) && (fwd_addr != 5'd0) && (r_q_addr[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_q_data[idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: vector table plus corner sequences, with a queue
// scoreboard checking every cycle's handshake, write port, count and forwarding.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        elk = 1'b0;
  logic        nrst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        rf_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [$clog2(DEPTH):0] pending_cnt;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .elk(elk), .nrst(nrst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_stall(rf_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending_cnt(pending_cnt), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 elk = ~elk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] av, aa, ad, mv, ma, md, st;
    logic [31:0] e_ar, e_mr, e_we, e_wa, e_wd, e_cnt;
  } vec_t;

  wr_t  sb_q[$];
  bit   m_rr = 1'b1;
  bit   sb_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vec[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_ready(output bit ar, output bit mr);
    ar = 1'b0;
    mr = 1'b0;
    if (nrst === 1'b1 && sb_q.size() < DEPTH) begin
      if (alu_valid && mem_valid) begin
        mr = m_rr;
        ar = !m_rr;
      end else begin
        ar = alu_valid;
        mr = mem_valid;
      end
    end
  endfunction

  // Reference model state advance at each active edge.
  always @(posedge elk or negedge nrst) begin
    bit ar, mr, we;
    if (!nrst) begin
      sb_q.delete();
      m_rr = 1'b1;
    end else begin
      model_ready(ar, mr);
      we = (sb_q.size() != 0) && !rf_stall;
      if (we) void'(sb_q.pop_front());
      if (alu_valid && mem_valid && (ar || mr)) m_rr = !m_rr;
      if (ar && alu_addr != 5'd0) sb_q.push_back('{alu_addr, alu_data});
      else if (mr && mem_addr != 5'd0) sb_q.push_back('{mem_addr, mem_data});
    end
  end

  // Scoreboard comparison on the inactive edge.
  always @(negedge elk) begin
    bit ar, mr, we, fh;
    logic [31:0] fd;
    if (sb_en) begin
      model_ready(ar, mr);
      we = (sb_q.size() != 0) && !rf_stall;
      chk("sb_alu_ready", alu_ready, ar);
      chk("sb_mem_ready", mem_ready, mr);
      chk("sb_wr_en", wr_en, we);
      chk("sb_pending_cnt", pending_cnt, sb_q.size());
      if (sb_q.size() != 0) begin
        chk("sb_wr_addr", wr_addr, sb_q[0].addr);
        chk("sb_wr_data", wr_data, sb_q[0].data);
      end else begin
        chk("sb_wr_addr_empty", wr_addr, 0);
        chk("sb_wr_data_empty", wr_data, 0);
      end
      fh = 1'b0;
      fd = 32'd0;
`ifdef WB_FORWARD_EN
      if (fwd_addr != 5'd0) begin
        foreach (sb_q[k]) begin
          if (sb_q[k].addr == fwd_addr) begin
            fh = 1'b1;
            fd = sb_q[k].data;
          end
        end
      end
`endif
      chk("sb_fwd_hit", fwd_hit, fh);
      chk("sb_fwd_data", fwd_data, fd);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge elk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
  endtask

  task automatic push_alu(input logic [4:0] a, input logic [31:0] d);
    alu_valid = 1'b1; alu_addr = a; alu_data = d;
    @(negedge elk);
    chk("push_alu_ready", alu_ready, 1);
    step();
    idle_inputs();
  endtask

  initial begin
    // av aa ad mv ma md st | e_ar e_mr e_we e_wa e_wd e_cnt
    vec[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 0, 0, 0, 0,             0, 0, 1, 5, 32'hDEADBEEF, 1};
    vec[2]  = '{1, 1, 32'hA1, 1, 2, 32'hB2, 0,   0, 1, 0, 0, 0, 0};
    vec[3]  = '{1, 3, 32'hA3, 1, 4, 32'hB4, 0,   1, 0, 1, 2, 32'hB2, 1};
    vec[4]  = '{1, 5, 32'hA5, 1, 6, 32'hB6, 0,   0, 1, 1, 3, 32'hA3, 1};
    vec[5]  = '{1, 7, 32'hA7, 1, 8, 32'hB8, 0,   1, 0, 1, 6, 32'hB6, 1};
    vec[6]  = '{1, 0, 32'h1234, 0, 0, 0, 0,      1, 0, 1, 7, 32'hA7, 1};
    vec[7]  = '{0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0};
    vec[8]  = '{0, 0, 0, 1, 9, 32'hC9, 1,        0, 1, 0, 0, 0, 0};
    vec[9]  = '{0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 9, 32'hC9, 1};
    vec[10] = '{0, 0, 0, 0, 0, 0, 0,             0, 0, 1, 9, 32'hC9, 1};
    vec[11] = '{0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0};
    vec[12] = '{1, 0, 32'h1234, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0};
    vec[13] = '{0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0};

    nrst = 1'b0;
    rf_stall = 1'b0;
    fwd_addr = 5'd0;
    idle_inputs();
    alu_valid = 1'b1; alu_addr = 5'd3; mem_valid = 1'b1; mem_addr = 5'd4;
    repeat (2) @(posedge elk);
    sb_en = 1'b1;
    @(negedge elk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_pending_cnt", pending_cnt, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    idle_inputs();
    step();
    nrst = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      alu_valid = vec[i].av[0]; alu_addr = vec[i].aa[4:0]; alu_data = vec[i].ad;
      mem_valid = vec[i].mv[0]; mem_addr = vec[i].ma[4:0]; mem_data = vec[i].md;
      rf_stall  = vec[i].st[0];
      @(negedge elk);
      chk($sformatf("v%0d_alu_ready", i), alu_ready, vec[i].e_ar);
      chk($sformatf("v%0d_mem_ready", i), mem_ready, vec[i].e_mr);
      chk($sformatf("v%0d_wr_en", i), wr_en, vec[i].e_we);
      chk($sformatf("v%0d_wr_addr", i), wr_addr, vec[i].e_wa);
      chk($sformatf("v%0d_wr_data", i), wr_data, vec[i].e_wd);
      chk($sformatf("v%0d_pending_cnt", i), pending_cnt, vec[i].e_cnt);
      step();
    end
    idle_inputs();
    rf_stall = 1'b0;

    // Fill under stall, fifth offer must wait, then drain in order.
    rf_stall = 1'b1;
    for (int k = 0; k < 4; k++) push_alu(5'(10 + k), 32'h100 + k);
    alu_valid = 1'b1; alu_addr = 5'd14; alu_data = 32'h104;
    for (int k = 0; k < 3; k++) begin
      @(negedge elk);
      chk("full_alu_ready", alu_ready, 0);
      chk("full_mem_ready", mem_ready, 0);
      chk("full_cnt", pending_cnt, 4);
      chk("full_wr_en", wr_en, 0);
      step();
    end
    rf_stall = 1'b0;
    @(negedge elk);
    chk("drain0_alu_ready", alu_ready, 0);
    chk("drain0_wr_addr", wr_addr, 10);
    step();
    @(negedge elk);
    chk("drain1_alu_ready", alu_ready, 1);
    chk("drain1_wr_addr", wr_addr, 11);
    step();
    idle_inputs();
    for (int k = 2; k < 5; k++) begin
      @(negedge elk);
      chk("drain_wr_en", wr_en, 1);
      chk("drain_wr_addr", wr_addr, 10 + k);
      chk("drain_wr_data", wr_data, 32'h100 + k);
      step();
    end
    @(negedge elk);
    chk("drained_cnt", pending_cnt, 0);
    step();

    // Forwarding of the youngest matching entry.
    rf_stall = 1'b1;
    push_alu(5'd7, 32'h11);
    push_alu(5'd7, 32'h22);
    fwd_addr = 5'd7;
    @(negedge elk);
`ifdef WB_FORWARD_EN
    chk("fwd7_hit", fwd_hit, 1);
    chk("fwd7_data", fwd_data, 32'h22);
`else
    chk("fwd7_hit_off", fwd_hit, 0);
    chk("fwd7_data_off", fwd_data, 0);
`endif
    step();
    fwd_addr = 5'd0;
    @(negedge elk);
    chk("fwd0_hit", fwd_hit, 0);
    step();
    fwd_addr = 5'd3;
    @(negedge elk);
    chk("fwd3_hit", fwd_hit, 0);
    step();
    fwd_addr = 5'd0;
    rf_stall = 1'b0;
    repeat (3) step();

    // Reset in the middle of a drain discards the remaining entries.
    rf_stall = 1'b1;
    push_alu(5'd20, 32'h200);
    push_alu(5'd21, 32'h201);
    push_alu(5'd22, 32'h202);
    rf_stall = 1'b0;
    @(negedge elk);
    chk("mid_wr_addr0", wr_addr, 20);
    step();
    @(negedge elk);
    chk("mid_wr_addr1", wr_addr, 21);
    alu_valid = 1'b1; alu_addr = 5'd23; alu_data = 32'h203;
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_cnt", pending_cnt, 0);
    chk("async_rst_alu_ready", alu_ready, 0);
    step();
    idle_inputs();
    nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge elk);
      chk("post_rst_wr_en", wr_en, 0);
      step();
    end

    sb_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
